// File: rtl/fp_add_seq_ctrl.sv
// fp_add_seq_ctrl: multi-cycle sequencer for the FP adder mantissa datapath.
// Accepts one operand pair per operation and steps the datapath through
// align, add, path select, iterative normalise and round, then presents
// the result with a valid/ready handshake.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready only in IDLE)
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   adder_top_bits    top 3 bits of the registered adder output
//   mant_msb          MSB of the datapath normalise register
//   mant_zero         adder mantissa result is all zero
//   ld_ops, align_en, add_en, round_en   single-cycle stage strobes
//   sel_left          mantissa mux select (1 = left/cancellation path)
//   norm_shift        shift the normalise register left one bit
//   zero_res          result is exact zero
//   norm_cnt          normalise shifts performed (for exponent adjust)
//   busy              an operation is in flight
module fp_add_seq_ctrl #(
  parameter int unsigned MANT_W   = 56,
  parameter int unsigned NORM_MAX = MANT_W - 1,
  parameter int unsigned CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [2:0]       adder_top_bits,
  input  logic             mant_msb,
  input  logic             mant_zero,
  output logic             ld_ops,
  output logic             align_en,
  output logic             add_en,
  output logic             sel_left,
  output logic             norm_shift,
  output logic             round_en,
  output logic             zero_res,
  output logic [CNT_W-1:0] norm_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_CHECK = 3'd3,
    S_NORM  = 3'd4,
    S_ROUND = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NORM_MAX);

  state_e           state_q, state_d;
  logic             sel_left_q, sel_left_d;
  logic             zero_res_q, zero_res_d;
  logic [CNT_W-1:0] norm_cnt_q, norm_cnt_d;

  // State and result-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_left_q <= 1'b0;
      zero_res_q <= 1'b0;
      norm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_left_q <= sel_left_d;
      zero_res_q <= zero_res_d;
      norm_cnt_q <= norm_cnt_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d    = state_q;
    sel_left_d = sel_left_q;
    zero_res_d = zero_res_q;
    norm_cnt_d = norm_cnt_q;
    ld_ops     = 1'b0;
    norm_shift = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ld_ops     = 1'b1;
          norm_cnt_d = '0;
          zero_res_d = 1'b0;
          state_d    = S_ALIGN;
        end
      end
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_CHECK;
      S_CHECK: begin
        // sel_left only changes here so the mux is steady through ROUND/DONE
        sel_left_d = (adder_top_bits == 3'b000);
        if (adder_top_bits != 3'b000) begin
          state_d = S_ROUND;
        end else if (mant_zero) begin
          zero_res_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        // Stop on a normalised MSB or at the shift limit; count never wraps
        if (mant_msb || (norm_cnt_q == CNT_MAX)) begin
          state_d = S_ROUND;
        end else begin
          norm_shift = 1'b1;
          norm_cnt_d = norm_cnt_q + CNT_W'(1);
        end
      end
      S_ROUND: state_d = S_DONE;
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign align_en  = (state_q == S_ALIGN);
  assign add_en    = (state_q == S_ADD);
  assign round_en  = (state_q == S_ROUND);
  assign busy      = (state_q != S_IDLE);
  assign sel_left  = sel_left_q;
  assign zero_res  = zero_res_q;
  assign norm_cnt  = norm_cnt_q;

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Scoreboard bench for fp_add_seq_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares when out_valid appears.
module tb_fp_add_seq_ctrl;

  localparam int unsigned CNT_W = 6;
  localparam int NORM_MAX = 55;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       adder_top_bits;
  logic             mant_msb;
  logic             mant_zero;
  logic             ld_ops;
  logic             align_en;
  logic             add_en;
  logic             sel_left;
  logic             norm_shift;
  logic             round_en;
  logic             zero_res;
  logic [CNT_W-1:0] norm_cnt;
  logic             busy;

  fp_add_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .adder_top_bits(adder_top_bits), .mant_msb(mant_msb), .mant_zero(mant_zero),
    .ld_ops(ld_ops), .align_en(align_en), .add_en(add_en),
    .sel_left(sel_left), .norm_shift(norm_shift), .round_en(round_en),
    .zero_res(zero_res), .norm_cnt(norm_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int sel;
    int zero;
    int cnt;
    int rounds;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;

  // Datapath stand-in: MSB becomes 1 after k_target left shifts
  int k_target = 0;
  int shift_seen = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_ops) shift_seen <= 0;
    else if (norm_shift) shift_seen <= shift_seen + 1;
  end
  assign mant_msb = (shift_seen >= k_target);

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor state
  bit   inflight = 0;
  bit   have_cur = 0;
  exp_t cur;
  int   acc_cyc, n_al, n_add, n_sh, n_rnd;

  always @(negedge clk) begin
    if (rst) begin
      inflight = 0;
      have_cur = 0;
    end else begin
      if (in_valid && in_ready) begin
        chk("ld_ops_on_accept", int'(ld_ops), 1);
        inflight = 1;
        acc_cyc = cyc;
        n_al = 0; n_add = 0; n_sh = 0; n_rnd = 0;
      end else if (inflight) begin
        n_al  += int'(align_en);
        n_add += int'(add_en);
        n_sh  += int'(norm_shift);
        n_rnd += int'(round_en);
      end
      if (out_valid) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            cur = sb.pop_front();
            chk("latency", cyc - acc_cyc, cur.lat);
            chk("sel_left", int'(sel_left), cur.sel);
            chk("zero_res", int'(zero_res), cur.zero);
            chk("norm_cnt", int'(norm_cnt), cur.cnt);
            chk("norm_shift_pulses", n_sh, cur.cnt);
            chk("round_pulses", n_rnd, cur.rounds);
            chk("align_pulses", n_al, 1);
            chk("add_pulses", n_add, 1);
            have_cur = 1;
            inflight = 0;
          end
        end else begin
          chk("hold_sel_left", int'(sel_left), cur.sel);
          chk("hold_zero_res", int'(zero_res), cur.zero);
          chk("hold_norm_cnt", int'(norm_cnt), cur.cnt);
        end
        chk("in_ready_in_done", int'(in_ready), 0);
        if (out_ready) have_cur = 0;
      end
    end
  end

  // Hand-derived expectation for an op with the given datapath behaviour
  task automatic push_exp(input logic [2:0] top, input bit mz, input int k);
    exp_t e;
    int   s;
    if (top != 3'b000) begin
      e = '{lat: 5, sel: 0, zero: 0, cnt: 0, rounds: 1};
    end else if (mz) begin
      e = '{lat: 4, sel: 1, zero: 1, cnt: 0, rounds: 0};
    end else begin
      s = (k > NORM_MAX) ? NORM_MAX : k;
      e = '{lat: 6 + s, sel: 1, zero: 0, cnt: s, rounds: 1};
    end
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !have_cur && in_ready) ok = 1;
    end
    if (!ok) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic issue(input logic [2:0] top, input bit mz, input int k, input bit hold);
    wait_idle();
    @(posedge clk); #1;
    adder_top_bits = top;
    mant_zero = mz;
    k_target = k;
    push_exp(top, mz, k);
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    adder_top_bits = 3'b000; mant_zero = 1'b0; k_target = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sel_left", int'(sel_left), 0);
    chk("rst_norm_cnt", int'(norm_cnt), 0);
    chk("rst_zero_res", int'(zero_res), 0);

    issue(3'b010, 1'b0, 0, 1'b0);   // right path
    issue(3'b000, 1'b0, 3, 1'b0);   // left path, 3 shifts
    issue(3'b000, 1'b1, 0, 1'b0);   // cancellation to zero
    issue(3'b000, 1'b0, 99, 1'b0);  // saturation at NORM_MAX
    issue(3'b000, 1'b0, 0, 1'b0);   // left path, already normalised
    issue(3'b100, 1'b0, 0, 1'b0);   // right path, other top bits

    // Backpressure with in_valid held throughout
    wait_idle();
    out_ready = 1'b0;
    issue(3'b000, 1'b0, 2, 1'b1);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    if (!ok) chk("bp_out_valid_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("bp_still_valid", int'(out_valid), 1);
    push_exp(3'b000, 1'b0, 2);      // next op will be taken after retire
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_in_ready", int'(in_ready), 1);
    chk("bp_idle_ld_ops", int'(ld_ops), 1);
    @(posedge clk); #1 in_valid = 1'b0;

    // Reset in the middle of normalisation
    issue(3'b000, 1'b0, 10, 1'b0);
    void'(sb.pop_back());           // this op is discarded by reset
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (shift_seen == 2) ok = 1;
    end
    if (!ok) chk("reset_wait_timeout", 0, 1);
    chk("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_norm_cnt", int'(norm_cnt), 0);
    chk("mid_rst_sel_left", int'(sel_left), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    repeat (20) @(negedge clk);     // any stray out_valid is flagged by the monitor

    issue(3'b000, 1'b0, 5, 1'b0);   // normal op after reset
    wait_idle();
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
